// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the controller state encoding and the default operand width,
// so the arithmetic blocks and the controller agree on both.
package seq_mul_pkg;

  // Default operand width in bits; the product is twice this wide.
  localparam int N_DEFAULT = 32;

  // Controller states. The encoding is fixed so that it stays stable
  // across revisions.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mul_mul_step.sv
// mul_step: one combinational shift-add step of an unsigned multiplier.
// Ports:
//   acc      - current 2N-bit accumulator {partial product, remaining multiplier bits}
//   mcand    - N-bit multiplicand
//   acc_next - accumulator after the conditional add and one right shift
module mul_step
  import seq_mul_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [2*N-1:0] acc,
  input  logic [N-1:0]   mcand,
  output logic [2*N-1:0] acc_next
);

  // The upper half is summed in N+1 bits so the carry shifts back into
  // the top of the accumulator instead of being lost.
  logic [N:0] sum;

  always_comb begin
    sum = {1'b0, acc[2*N-1:N]};
    if (acc[0]) begin
      sum = {1'b0, acc[2*N-1:N]} + {1'b0, mcand};
    end
    acc_next = {sum, acc[N-1:1]};
  end

endmodule

// File: rtl/seq_mul.sv
// seq_mul: sequential unsigned multiplier, one shift-add step per clock.
// Ports:
//   clk   - clock, rising edge active
//   rst_n - asynchronous active-low reset
//   start - request a multiply; accepted in IDLE or DONE
//   a, b  - N-bit unsigned operands, captured when start is accepted
//   busy  - high while the multiply is running
//   done  - one-cycle pulse when p holds a new product
//   p     - 2N-bit registered product, held until the next done
module seq_mul
  import seq_mul_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  // count must be able to reach N, hence one extra bit.
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  state_t          state;
  logic [CW-1:0]   count;
  logic [N-1:0]    mcand;
  logic [2*N-1:0]  acc;
  logic [2*N-1:0]  acc_next;

  mul_step #(.N(N)) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .acc_next (acc_next)
  );

  // Controller and datapath registers. busy and done are updated together
  // with the state so they are registered and never overlap. A start seen
  // in DONE is accepted directly, which gives back-to-back operation with
  // no idle cycle in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
      count <= '0;
      acc   <= '0;
      mcand <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a;
            acc   <= {{N{1'b0}}, b};
            count <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          // The Nth step lands straight in p so the product is visible
          // in the same cycle that done pulses.
          if (count == LAST_STEP) begin
            p     <= acc_next;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul.sv
// tb_seq_mul: self-checking bench for seq_mul with N=32.
// A protocol-level model (remaining-cycle counter plus a queued product)
// predicts busy/done/p every cycle; directed tests add literal products.
module tb_seq_mul;

  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*N-1:0] p;

  int checks = 0;
  int errors = 0;

  seq_mul #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  // Model state: whether a product is pending, how many clocks remain,
  // and the product computed with plain arithmetic at acceptance.
  logic           m_busy;
  logic           m_done;
  logic [2*N-1:0] m_p;
  logic [2*N-1:0] pending;
  int             left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_p     <= '0;
      pending <= '0;
      left    <= 0;
    end else if (m_busy) begin
      left <= left - 1;
      if (left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_p    <= pending;
      end else begin
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        pending <= {{N{1'b0}}, a} * {{N{1'b0}}, b};
        left    <= N;
        m_busy  <= 1'b1;
      end
    end
  end

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Every-cycle comparison against the model while out of reset.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      check_output("cycle busy", 64'(busy), 64'(m_busy));
      check_output("cycle done", 64'(done), 64'(m_done));
      check_output("cycle p", p, m_p);
      check_output("busy and done exclusive", 64'(busy & done), 64'd0);
    end
  end

  // Single multiply with latency, busy-length and literal product checks.
  task automatic apply_stimulus(input string name, input logic [N-1:0] av,
                                input logic [N-1:0] bv, input logic [63:0] exp_p);
    int k;
    int bc;
    @(negedge clk);
    start = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    start = 1'b0;
    bc = busy ? 1 : 0;
    k = 0;
    while (k < N + 4 && !done) begin
      @(posedge clk);
      #2;
      k++;
      if (!done && busy) bc++;
    end
    check_output({name, " latency"}, 64'(k), 64'(N));
    check_output({name, " busy cycles"}, 64'(bc), 64'(N));
    check_output({name, " p"}, p, exp_p);
    check_output({name, " model p"}, m_p, exp_p);
  endtask

  // Wait for done with a cycle bound; returns cycles waited.
  task automatic wait_done(output int k);
    k = 0;
    while (k < N + 4 && !done) begin
      @(posedge clk);
      #2;
      k++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    int dn;
    int early;

    // Reset state.
    repeat (3) @(negedge clk);
    check_output("reset busy", 64'(busy), 64'd0);
    check_output("reset done", 64'(done), 64'd0);
    check_output("reset p", p, 64'd0);
    rst_n = 1'b1;

    apply_stimulus("basic 3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
    apply_stimulus("max ffffffff^2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    apply_stimulus("msb x2", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);

    // Start while busy: the second start must be ignored.
    @(negedge clk);
    start = 1'b1; a = 32'd7; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    dn = 0;
    early = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #2;
      if (done) dn++;
      if (dn == 0 && p !== 64'h0000_0001_0000_0000) early++;
    end
    check_output("busy-start done pulses", 64'(dn), 64'd1);
    check_output("busy-start p held", 64'(early), 64'd0);
    check_output("busy-start p", p, 64'd63);

    apply_stimulus("zero", 32'd0, 32'hDEAD_BEEF, 64'd0);

    // Back-to-back: start held high, new operands offered in DONE.
    @(negedge clk);
    start = 1'b1; a = 32'd2; b = 32'd3;
    @(negedge clk);
    wait_done(k);
    check_output("b2b first done", 64'(done), 64'd1);
    check_output("b2b first p", p, 64'd6);
    check_output("b2b busy in done", 64'(busy), 64'd0);
    a = 32'd4; b = 32'd5;
    @(posedge clk);
    #2;
    start = 1'b0;
    check_output("b2b busy after done", 64'(busy), 64'd1);
    check_output("b2b done dropped", 64'(done), 64'd0);
    wait_done(k);
    check_output("b2b second latency", 64'(k), 64'(N));
    check_output("b2b second p", p, 64'd20);

    // Reset mid-run, with start asserted while reset is held.
    @(negedge clk);
    start = 1'b1; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("midrun reset busy", 64'(busy), 64'd0);
    check_output("midrun reset done", 64'(done), 64'd0);
    check_output("midrun reset p", p, 64'd0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < N + 4; i++) begin
      @(posedge clk);
      #2;
      if (done || busy) dn++;
    end
    check_output("after reset quiet", 64'(dn), 64'd0);
    apply_stimulus("after reset 6x7", 32'd6, 32'd7, 64'd42);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mul.md
SEQ_MUL -- requirements
Module: seq_mul

Interface
REQ-001 SHALL have parameter N, default 32, operand width in bits; the product width is 2N.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to begin a multiply; sampled on the clk rising edge.
REQ-005 SHALL have port a, input, N, multiplicand, unsigned; sampled only when start is accepted.
REQ-006 SHALL have port b, input, N, multiplier, unsigned; sampled only when start is accepted.
REQ-007 SHALL have port busy, output, 1, high while a multiply is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking p valid.
REQ-009 SHALL have port p, output, 2N, registered unsigned product.

Function
REQ-010 SHALL implement an FSM with three states: IDLE, RUN and DONE.
REQ-011 SHALL accept start only in IDLE or DONE; on acceptance it SHALL load mcand=a, acc={N'b0,b}, count=0, and enter RUN.
REQ-012 SHALL perform exactly one shift-add step per clock in RUN: if acc[0]=1, {c,hi}=acc[2N-1:N]+mcand (N+1 bits, carry kept), else {c,hi}={1'b0,acc[2N-1:N]}; then acc={c,hi,acc[N-1:1]}.
REQ-013 SHALL increment count on every RUN step and leave RUN for DONE after the Nth step.
REQ-014 SHALL latch p=acc on entry to DONE, assert done for exactly that one cycle, then return to IDLE unless start is accepted in that cycle.
REQ-015 SHALL hold p stable from DONE until the next DONE; p SHALL NOT change during RUN.
REQ-016 SHALL give a latency of N cycles: start sampled at edge E0 gives done=1 and p valid in the cycle following edge EN.
REQ-017 SHALL ignore start while in RUN; a, b and the in-flight result SHALL be unaffected.
REQ-018 SHALL accept start asserted during the DONE cycle (back-to-back): done pulses, busy rises in the next cycle, and no idle cycle is inserted.
REQ-019 SHALL assert busy exactly when state=RUN; busy and done SHALL never be high together.
REQ-020 SHALL produce the exact unsigned 2N-bit product for all operand values, with no overflow possible.

Reset
REQ-021 SHALL, on rst_n low, immediately force state=IDLE, busy=0, done=0, p=0, count=0 and acc=0, regardless of clk.
REQ-022 SHALL abandon any multiply in progress on reset mid-operation, with no done pulse; the first start after rst_n rises SHALL begin a fresh operation.
REQ-023 SHALL sample no start input during a cycle in which rst_n is low.

Structure
REQ-024 SHALL place the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default width N=32 in a shared package or header used by all arithmetic blocks.
REQ-025 SHALL size count at clog2(N)+1 bits so it can hold the value N.
REQ-026 SHALL use one sub-module, mul_step: a combinational block implementing the conditional (N+1)-bit add and right shift of REQ-012; the FSM and registers SHALL remain in seq_mul.
REQ-027 SHALL be synthesizable, with no delay annotations in the RTL.

Verification
REQ-028 Basic: start with a=3, b=5 -> done exactly 32 cycles later, p=64'h0000_0000_0000_000F, busy high for 32 cycles.
REQ-029 Max operands: a=b=32'hFFFF_FFFF -> p=64'hFFFF_FFFE_0000_0001; a=32'h8000_0000, b=2 -> p=64'h0000_0001_0000_0000.
REQ-030 Zero: a=0, b=32'hDEAD_BEEF -> p=0, with done pulse timing identical to the basic case.
REQ-031 Start while busy: start a=7, b=9, then pulse start with a=1, b=1 at cycle 10 -> p=63, one done pulse only, p unchanged until that pulse.
REQ-032 Back-to-back: hold start high with a=2, b=3, then a=4, b=5 in the DONE cycle -> p=6 with done, p=20 32 cycles later, and busy low only during the DONE cycles.
REQ-033 Reset mid-run: rst_n low at cycle 15 -> busy, done and p are 0 immediately and no done follows; a new start with a=6, b=7 -> p=42.
